// File: rtl/csr_uart_tx_if.sv
// csr_uart_tx_if: CSR operation type and the decoder-side CSR bus shared by CSR peripherals.
package csr_uart_tx_pkg;
    typedef enum logic [2:0] {
        CSR_NONE = 3'b000,
        CSR_RW   = 3'b001,
        CSR_RS   = 3'b010,
        CSR_RC   = 3'b011,
        CSR_RWI  = 3'b101,
        CSR_RSI  = 3'b110,
        CSR_RCI  = 3'b111
    } csr_t;
endpackage

interface csr_uart_tx_if;
    import csr_uart_tx_pkg::*;
    logic        en;
    logic [11:0] csr_addr;
    csr_t        op;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic [31:0] in;
    logic [31:0] old;
    modport master (output en, csr_addr, op, rs1, rd, in, input old);
    modport slave  (input en, csr_addr, op, rs1, rd, in, output old);
endinterface

// File: rtl/csr_uart_tx.sv
// csr_uart_tx: CSR-mapped 8N1 UART transmitter with a small byte FIFO and a status read value.
module csr_uart_tx
    import csr_uart_tx_pkg::*;
#(
    parameter logic [11:0] CsrAddr   = 12'h052,
    parameter int          BaudDiv   = 174,
    parameter int          FifoDepth = 4
) (
    input  logic          clk,
    input  logic          reset,
    csr_uart_tx_if.slave  bus,
    output logic          tx
);
    localparam int AW = $clog2(FifoDepth);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(BaudDiv);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem_q [FifoDepth];
    logic [7:0]      mem_d [FifoDepth];
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            sel, push, pop, accept, clr, full, empty, tick;
    logic            bits_unused;

    assign sel    = bus.en && bus.csr_addr == CsrAddr;
    assign full   = count_q == CW'(FifoDepth);
    assign empty  = count_q == '0;
    assign tick   = baud_q == BW'(BaudDiv - 1);
    assign push   = sel && (bus.op == CSR_RW || bus.op == CSR_RWI);
    assign clr    = sel && (bus.op == CSR_RC || bus.op == CSR_RCI) && bus.rs1 != '0 && bus.in[3];
    // The FIFO is drained from IDLE, or at the end of a stop bit to chain frames without a gap.
    assign pop    = !empty && (state_q == IDLE || (state_q == STOP && tick));
    assign accept = push && (!full || pop);
    assign bus.old = {24'h0, 4'(count_q), ovf_q, state_q != IDLE, empty, full};
    assign tx = tx_q;
    assign bits_unused = ^{bus.rd, bus.in[31:8]};

    always_comb begin
        state_d = state_q;
        baud_d  = tick ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (pop) begin
                    state_d = START;
                    shift_d = mem_q[rptr_q];
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    state_d = bit_q == 3'd7 ? STOP : DATA;
                end
            end
            default: begin
                if (tick) begin
                    state_d = pop ? START : IDLE;
                    shift_d = pop ? mem_q[rptr_q] : shift_q;
                end
            end
        endcase
        tx_d = state_d == DATA ? shift_d[0] : state_d != START;
    end

    always_comb begin
        mem_d = mem_q;
        if (accept) mem_d[wptr_q] = bus.in[7:0];
        wptr_d  = accept ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q + CW'(accept) - CW'(pop);
        ovf_d   = (push && full && !pop) || (ovf_q && !clr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            mem_q   <= '{default: '0};
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end
endmodule
